// File: rtl/ccff_loader_pkg.sv
// Shared definitions for the ccff chain loader: FSM state encoding and
// the counter-width helper used to size the chain and bit counters.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Width of a counter that must hold every value 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ccff_word_shifter.sv
// One host word in flight: a PISO feeding the chain head and a SIPO
// collecting the chain tail, plus the bit index within the current word.
// The SIPO keeps only WORD_W-1 bits; the final tail bit of a word is
// merged combinationally in o_sipo_next so the readback word is ready
// in the same cycle as the last shift.
module ccff_word_shifter
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_load_data,
    input  logic              i_shift,
    input  logic              i_ser_in,
    output logic              o_ser_out,
    output logic [WORD_W-1:0] o_sipo_next,
    output logic              o_last_bit
);
    localparam int IDX_W = cnt_width(WORD_W - 1);

    logic [WORD_W-1:0] r_piso;
    logic [WORD_W-2:0] r_sipo;
    logic [IDX_W-1:0]  r_bit_idx;

    assign o_ser_out   = r_piso[WORD_W-1];
    assign o_sipo_next = {r_sipo, i_ser_in};
    assign o_last_bit  = (r_bit_idx == IDX_W'(WORD_W - 1));

    // Load a fresh word (clearing readback so partial words come out
    // right-aligned), or advance both shift registers by one bit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: registers take non-blocking assignments so every flop in
        // the design samples pre-edge values regardless of block order.
        if (i_rst) begin
            r_piso    <= '0;
            r_sipo    <= '0;
            r_bit_idx <= '0;
        end else if (i_load) begin
            r_piso    <= i_load_data;
            r_sipo    <= '0;
            r_bit_idx <= '0;
        end else if (i_shift) begin
            r_piso    <= {r_piso[WORD_W-2:0], 1'b0};
            r_sipo    <= o_sipo_next[WORD_W-2:0];
            r_bit_idx <= r_bit_idx + 1'b1;
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads the fabric ccff chain from host words: fetch a word over
// valid/ready, shift it MSB-first onto ccff_head with the chain clock
// enabled, and return the bits pushed out of ccff_tail as readback.
// abort and pReset both cut the chain clock without waiting for an edge.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              chain_clk_en,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = cnt_width(CHAIN_LEN);

    state_e            r_state;
    state_e            w_next_state;
    logic [CNT_W-1:0]  r_chain_cnt;
    logic              r_rd_valid;
    logic [WORD_W-1:0] r_rd_data;
    logic              w_load;
    logic              w_shift;
    logic              w_last_bit;
    logic              w_last_chain;
    logic              w_word_end;
    logic              w_ser_out;
    logic [WORD_W-1:0] w_sipo_next;

    assign w_load       = (r_state == ST_FETCH) && wr_valid && !abort;
    assign w_shift      = (r_state == ST_SHIFT) && !abort;
    assign w_last_chain = (r_chain_cnt == CNT_W'(CHAIN_LEN - 1));
    assign w_word_end   = w_shift && (w_last_bit || w_last_chain);

    ccff_word_shifter #(
        .WORD_W (WORD_W)
    ) u_shifter (
        .i_clk       (prog_clk),
        .i_rst       (pReset),
        .i_load      (w_load),
        .i_load_data (wr_data),
        .i_shift     (w_shift),
        .i_ser_in    (ccff_tail),
        .o_ser_out   (w_ser_out),
        .o_sipo_next (w_sipo_next),
        .o_last_bit  (w_last_bit)
    );

    // State register.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic; abort overrides everything, including start in IDLE.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_next_state = r_state;
        if (abort) begin
            w_next_state = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE:  if (start)    w_next_state = ST_FETCH;
                ST_FETCH: if (wr_valid) w_next_state = ST_SHIFT;
                ST_SHIFT: if (w_last_bit || w_last_chain)
                              w_next_state = w_last_chain ? ST_DONE : ST_FETCH;
                ST_DONE:  w_next_state = ST_IDLE;
                default:  w_next_state = ST_IDLE;
            endcase
        end
    end

    // Moore outputs, with abort gating the chain clock and handshake at once.
    always_comb begin
        wr_ready     = (r_state == ST_FETCH) && !abort;
        chain_clk_en = w_shift;
        busy         = (r_state != ST_IDLE);
        done         = (r_state == ST_DONE) && !abort;
    end

    // Chain bit count for the whole load, restarted by an accepted start.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset)                                     r_chain_cnt <= '0;
        else if (r_state == ST_IDLE && start && !abort) r_chain_cnt <= '0;
        else if (w_shift)                               r_chain_cnt <= r_chain_cnt + 1'b1;
    end

    // Readback word and its one-cycle valid pulse at every completed word.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_word_end;
            if (w_word_end) r_rd_data <= w_sipo_next;
        end
    end

    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign ccff_head = w_ser_out;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench: two loaders (64-bit chain and 20-bit chain, 8-bit words)
// each drive a behavioural fabric chain. The driver pushes the expected head
// stream, readback words and done timing; a monitor pops and compares.
module tb_ccff_chain_loader;
    localparam int WW = 8;

    typedef struct { int id; logic [WW-1:0] v; } rd_exp_t;
    typedef struct { int id; bit b; } head_exp_t;
    typedef struct { int id; int cyc; int en; } done_exp_t;

    logic          prog_clk;
    logic          pReset;
    logic          start_s    [2];
    logic          abort_s    [2];
    logic [WW-1:0] wr_data_s  [2];
    logic          wr_valid_s [2];
    logic          wr_ready_s [2];
    logic [WW-1:0] rd_data_s  [2];
    logic          rd_valid_s [2];
    logic          head_s     [2];
    logic          tail_s     [2];
    logic          clk_en_s   [2];
    logic          busy_s     [2];
    logic          done_s     [2];

    bit [63:0]     env_chain [2];
    bit            model_seq [2][64];
    logic [WW-1:0] wbuf [8];
    int            edge_cnt   = 0;
    int            drv_err    = 0;
    bit            tests_done = 0;
    int            n_checks   = 0;
    int            n_errs     = 0;

    rd_exp_t   exp_rd[$];
    head_exp_t exp_head[$];
    done_exp_t exp_done[$];

    ccff_chain_loader #(.CHAIN_LEN(64), .WORD_W(WW)) dut0 (
        .prog_clk(prog_clk), .pReset(pReset), .start(start_s[0]), .abort(abort_s[0]),
        .wr_data(wr_data_s[0]), .wr_valid(wr_valid_s[0]), .wr_ready(wr_ready_s[0]),
        .rd_data(rd_data_s[0]), .rd_valid(rd_valid_s[0]), .ccff_head(head_s[0]),
        .ccff_tail(tail_s[0]), .chain_clk_en(clk_en_s[0]), .busy(busy_s[0]), .done(done_s[0])
    );

    ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(WW)) dut1 (
        .prog_clk(prog_clk), .pReset(pReset), .start(start_s[1]), .abort(abort_s[1]),
        .wr_data(wr_data_s[1]), .wr_valid(wr_valid_s[1]), .wr_ready(wr_ready_s[1]),
        .rd_data(rd_data_s[1]), .rd_valid(rd_valid_s[1]), .ccff_head(head_s[1]),
        .ccff_tail(tail_s[1]), .chain_clk_en(clk_en_s[1]), .busy(busy_s[1]), .done(done_s[1])
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    always @(posedge prog_clk) edge_cnt <= edge_cnt + 1;

    // Fabric chains: plain shift registers clocked only while enabled.
    always @(posedge prog_clk) begin
        for (int i = 0; i < 2; i++)
            if (clk_en_s[i]) env_chain[i] <= {env_chain[i][62:0], head_s[i]};
    end
    assign tail_s[0] = env_chain[0][63];
    assign tail_s[1] = env_chain[1][19];

    function automatic int cl_of(input int id);
        return (id == 0) ? 64 : 20;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fill_random(input int nw);
        for (int j = 0; j < nw; j++) wbuf[j] = WW'($urandom);
    endtask

    // One load on DUT id. k = bits the chain actually advances (CHAIN_LEN,
    // or fewer when abort_at / reset_at cut the load short).
    task automatic run_load(input int id, input int nw, input int stall_w, input int stall_len,
                            input int abort_at, input int reset_at, input int glitch_cyc);
        int cl = cl_of(id);
        int n = 0, k, nb, widx = 0, stalls = 0, shifts = 0, it = 0;
        bit fin = 0;
        bit s[64];
        bit t[64];
        logic [WW-1:0] v;
        for (int j = 0; j < nw; j++) begin
            nb = (cl - j * WW < WW) ? cl - j * WW : WW;
            for (int b = 0; b < nb; b++) begin s[n] = wbuf[j][WW-1-b]; n++; end
        end
        k = (abort_at >= 0) ? abort_at : (reset_at >= 0) ? reset_at : cl;
        // Readback: the chain is a FIFO, so the first k bits out are the
        // oldest k bits in it, grouped into words and right-aligned.
        for (int j = 0; j < ((k == cl) ? nw : k / WW); j++) begin
            nb = (cl - j * WW < WW) ? cl - j * WW : WW;
            v = '0;
            for (int b = 0; b < nb; b++) v = {v[WW-2:0], model_seq[id][j*WW+b]};
            exp_rd.push_back('{id: id, v: v});
        end
        for (int x = 0; x < cl; x++) t[x] = (x < cl - k) ? model_seq[id][x+k] : s[x-(cl-k)];
        for (int x = 0; x < cl; x++) model_seq[id][x] = t[x];
        for (int x = 0; x < cl; x++) exp_head.push_back('{id: id, b: s[x]});
        if (k == cl) exp_done.push_back('{id: id, cyc: nw + cl + 1 + stall_len, en: cl});

        while (!fin && it < 400) begin
            @(negedge prog_clk);
            start_s[id] = (it == 0) || (it == glitch_cyc);
            if (widx < nw && !(widx == stall_w && stalls < stall_len)) begin
                wr_valid_s[id] = 1'b1;
                wr_data_s[id]  = wbuf[widx];
            end else begin
                wr_valid_s[id] = 1'b0;
            end
            abort_s[id] = (abort_at >= 0) && (shifts == abort_at) && clk_en_s[id];
            #1;
            if (abort_s[id]) begin
                fin = 1;
            end else begin
                if (wr_ready_s[id] && wr_valid_s[id]) widx++;
                else if (wr_ready_s[id])              stalls++;
                if (clk_en_s[id]) shifts++;
                if (done_s[id])   fin = 1;
                if (reset_at >= 0 && clk_en_s[id] && shifts == reset_at) begin
                    @(posedge prog_clk);
                    #2;
                    pReset = 1'b1;
                    fin = 1;
                end
            end
            it++;
        end
        if (!fin) drv_err++;
        if (k < cl) exp_head.delete();
        @(negedge prog_clk);
        start_s[id] = 1'b0; abort_s[id] = 1'b0; wr_valid_s[id] = 1'b0;
        if (reset_at >= 0) begin @(negedge prog_clk); pReset = 1'b0; end
    endtask

    initial begin : driver
        pReset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 0; abort_s[i] = 0; wr_valid_s[i] = 0; wr_data_s[i] = '0;
        end
        repeat (3) @(negedge prog_clk);
        pReset = 1'b0;
        @(negedge prog_clk);

        // Full load of 0xA5..0xAC; readback of the reset chain is all zero.
        for (int j = 0; j < 8; j++) wbuf[j] = WW'(8'hA5 + j);
        run_load(0, 8, -1, 0, -1, -1, -1);
        // Preload 0x3C everywhere (reads back A5..AC), then read 0x3C back.
        for (int j = 0; j < 8; j++) wbuf[j] = 8'h3C;
        run_load(0, 8, -1, 0, -1, -1, -1);
        fill_random(8);
        run_load(0, 8, -1, 0, -1, -1, 20);
        // Five-cycle stall before the third word.
        fill_random(8);
        run_load(0, 8, 2, 5, -1, -1, -1);

        // 20-bit chain: last word 0xF0 only contributes its top nibble.
        fill_random(2); wbuf[2] = 8'hF0;
        run_load(1, 3, -1, 0, -1, -1, -1);
        fill_random(3);
        run_load(1, 3, 1, 2, -1, -1, -1);
        fill_random(3);
        run_load(1, 3, -1, 0, -1, -1, -1);

        // Abort in the 3rd shift cycle of the second word.
        fill_random(8);
        run_load(0, 8, -1, 0, 10, -1, -1);
        repeat (2) @(negedge prog_clk);
        // start and abort together in IDLE: stay idle.
        start_s[0] = 1'b1; abort_s[0] = 1'b1;
        @(negedge prog_clk);
        start_s[0] = 1'b0; abort_s[0] = 1'b0;
        repeat (2) @(negedge prog_clk);
        fill_random(8);
        run_load(0, 8, -1, 0, -1, -1, -1);

        // Asynchronous reset in the middle of the fourth word.
        fill_random(8);
        run_load(0, 8, -1, 0, -1, 28, -1);
        fill_random(8);
        run_load(0, 8, -1, 0, -1, -1, -1);

        for (int r = 0; r < 4; r++) begin
            int id = r % 2;
            fill_random(8);
            run_load(id, (id == 0) ? 8 : 3, int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 3)), -1, -1, -1);
        end
        repeat (3) @(negedge prog_clk);
        tests_done = 1;
    end

    initial begin : monitor
        bit        prev_abort [2];
        bit        prev_ready [2];
        bit        prev_head  [2];
        int        start_edge [2];
        int        en_cnt     [2];
        int        samples = 0;
        rd_exp_t   er;
        head_exp_t eh;
        done_exp_t ed;
        forever begin
            @(negedge prog_clk);
            #2;
            samples++;
            for (int i = 0; i < 2; i++) begin
                if (pReset) begin
                    check($sformatf("reset_outputs[%0d]", i),
                          32'({wr_ready_s[i], rd_valid_s[i], head_s[i], clk_en_s[i],
                               busy_s[i], done_s[i], rd_data_s[i]}), 32'd0);
                    prev_abort[i] = 0;
                    prev_ready[i] = 0;
                end else begin
                    if (prev_abort[i]) check($sformatf("busy_after_abort[%0d]", i), 32'(busy_s[i]), 32'd0);
                    if (abort_s[i])    check($sformatf("clk_en_in_abort[%0d]", i), 32'(clk_en_s[i]), 32'd0);
                    if (start_s[i] && !busy_s[i] && !abort_s[i]) begin
                        start_edge[i] = edge_cnt;
                        en_cnt[i] = 0;
                    end
                    if (clk_en_s[i]) begin
                        en_cnt[i]++;
                        if (exp_head.size() == 0 || exp_head[0].id != i) begin
                            n_checks++; n_errs++;
                            $display("FAIL head[%0d]: got unexpected chain_clk_en, required none", i);
                        end else begin
                            eh = exp_head.pop_front();
                            check($sformatf("ccff_head[%0d]", i), 32'(head_s[i]), 32'(eh.b));
                        end
                    end
                    if (rd_valid_s[i]) begin
                        if (exp_rd.size() == 0 || exp_rd[0].id != i) begin
                            n_checks++; n_errs++;
                            $display("FAIL rd_valid[%0d]: got unexpected pulse data 0x%0h, required none", i, rd_data_s[i]);
                        end else begin
                            er = exp_rd.pop_front();
                            check($sformatf("rd_data[%0d]", i), 32'(rd_data_s[i]), 32'(er.v));
                        end
                    end
                    if (done_s[i]) begin
                        if (exp_done.size() == 0 || exp_done[0].id != i) begin
                            n_checks++; n_errs++;
                            $display("FAIL done[%0d]: got unexpected pulse, required none", i);
                        end else begin
                            ed = exp_done.pop_front();
                            check($sformatf("done_cycle[%0d]", i), 32'(edge_cnt - start_edge[i]), 32'(ed.cyc));
                            check($sformatf("clk_en_count[%0d]", i), 32'(en_cnt[i]), 32'(ed.en));
                        end
                    end
                    if (wr_ready_s[i] && prev_ready[i]) begin
                        check($sformatf("stall_head_frozen[%0d]", i), 32'(head_s[i]), 32'(prev_head[i]));
                        check($sformatf("stall_clk_en[%0d]", i), 32'(clk_en_s[i]), 32'd0);
                    end
                    prev_abort[i] = abort_s[i];
                    prev_ready[i] = wr_ready_s[i];
                    prev_head[i]  = head_s[i];
                end
            end
            if (tests_done || samples > 20000) begin
                if (!tests_done) begin
                    n_checks++; n_errs++;
                    $display("FAIL watchdog: got %0d cycles without completion, required fewer", samples);
                end
                check("pending_rd", 32'(exp_rd.size()), 32'd0);
                check("pending_head", 32'(exp_head.size()), 32'd0);
                check("pending_done", 32'(exp_done.size()), 32'd0);
                check("driver_timeouts", 32'(drv_err), 32'd0);
                $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
                $finish;
            end
        end
    end

endmodule
